// File: rtl/fp_mult_scheduler.sv
// Round-robin scheduler sharing one pipelined FP multiplier among NREQ requesters.
// Optional STATUS_STICKY_EN adds per-requester sticky status flags (sticky_status / sticky_clr).
module fp_mult_scheduler #(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_rnd,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [NREQ*32-1:0] resp_z,
  output logic [NREQ*8-1:0]  resp_status,
  output logic [31:0]        mult_a,
  output logic [31:0]        mult_b,
  output logic [2:0]         mult_rnd,
  output logic               mult_valid,
  input  logic [31:0]        mult_z,
  input  logic [0:7]         mult_status,
  output logic               busy
`ifdef STATUS_STICKY_EN
  ,
  output logic [NREQ*8-1:0]  sticky_status,
  input  logic [NREQ-1:0]    sticky_clr
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    outstanding_q;
  logic [NREQ-1:0]    respValid_q;
  logic [NREQ*32-1:0] respZ_q;
  logic [NREQ*8-1:0]  respStatus_q;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [31:0]        multA_q, multB_q;
  logic [2:0]         multRnd_q;
  logic               multValid_q;
  logic [IW-1:0]      issueIdx_q;
  logic [LAT-1:0]     tagValid_q;
  logic [IW-1:0]      tagIdx_q [LAT];

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] respFire;
  logic            grantAny;
  logic [IW-1:0]   grantIdx;
  logic [IW-1:0]   cand;
  logic            capValid;
  logic [IW-1:0]   capIdx;

  assign eligible = req_valid & ~outstanding_q & {NREQ{~rst}};
  assign respFire = respValid_q & resp_ready;
  assign capValid = tagValid_q[LAT-1];
  assign capIdx   = tagIdx_q[LAT-1];

  // Rotating priority: the first eligible requester at or after ptr_q wins.
  always_comb begin
    grant    = '0;
    grantAny = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!grantAny && eligible[cand]) begin
        grantAny    = 1'b1;
        grantIdx    = cand;
        grant[cand] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (grantAny)
      ptr_d = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      multA_q       <= '0;
      multB_q       <= '0;
      multRnd_q     <= '0;
      multValid_q   <= 1'b0;
      issueIdx_q    <= '0;
      tagValid_q    <= '0;
      for (int s = 0; s < LAT; s++) tagIdx_q[s] <= '0;
      outstanding_q <= '0;
      respValid_q   <= '0;
      respZ_q       <= '0;
      respStatus_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      multValid_q <= grantAny;
      if (grantAny) begin
        multA_q    <= req_a[32*grantIdx +: 32];
        multB_q    <= req_b[32*grantIdx +: 32];
        multRnd_q  <= req_rnd[3*grantIdx +: 3];
        issueIdx_q <= grantIdx;
      end
      // Tag pipe runs in step with the multiplier so results land in the right buffer.
      tagValid_q[0] <= multValid_q;
      tagIdx_q[0]   <= issueIdx_q;
      for (int s = 1; s < LAT; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagIdx_q[s]   <= tagIdx_q[s-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i])
          outstanding_q[i] <= 1'b1;
        else if (respFire[i])
          outstanding_q[i] <= 1'b0;
        if (capValid && capIdx == IW'(i)) begin
          respValid_q[i]         <= 1'b1;
          respZ_q[32*i +: 32]    <= mult_z;
          respStatus_q[8*i +: 8] <= mult_status;
        end else if (respFire[i]) begin
          respValid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef STATUS_STICKY_EN
  logic [NREQ*8-1:0] sticky_q;

  // A clear arriving with a capture still keeps that capture's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capValid && capIdx == IW'(i))
          sticky_q[8*i +: 8] <= (sticky_clr[i] ? 8'h00 : sticky_q[8*i +: 8]) | mult_status;
        else if (sticky_clr[i])
          sticky_q[8*i +: 8] <= 8'h00;
      end
    end
  end

  assign sticky_status = sticky_q;
`endif

  assign req_ready   = grant;
  assign resp_valid  = respValid_q;
  assign resp_z      = respZ_q;
  assign resp_status = respStatus_q;
  assign mult_a      = multA_q;
  assign mult_b      = multB_q;
  assign mult_rnd    = multRnd_q;
  assign mult_valid  = multValid_q;
  assign busy        = |outstanding_q;

endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Directed bench for fp_mult_scheduler with a table-driven stand-in multiplier of latency LAT.
// Define STATUS_STICKY_EN to also exercise the sticky status ports.
module tb_fp_mult_scheduler;

  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int P    = LAT + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0] req_rnd;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [NREQ*32-1:0] resp_z;
  logic [NREQ*8-1:0] resp_status;
  logic [31:0]       mult_a;
  logic [31:0]       mult_b;
  logic [2:0]        mult_rnd;
  logic              mult_valid;
  logic [31:0]       mult_z;
  logic [0:7]        mult_status;
  logic              busy;
`ifdef STATUS_STICKY_EN
  logic [NREQ*8-1:0] sticky_status;
  logic [NREQ-1:0]   sticky_clr;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fp_mult_scheduler #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_status(resp_status),
    .mult_a(mult_a), .mult_b(mult_b), .mult_rnd(mult_rnd), .mult_valid(mult_valid),
    .mult_z(mult_z), .mult_status(mult_status),
    .busy(busy)
`ifdef STATUS_STICKY_EN
    , .sticky_status(sticky_status), .sticky_clr(sticky_clr)
`endif
  );

  // Known products; status byte is [0:7] = zero,inf,nan,... so nan is packed bit 5 (8'h20).
  function automatic logic [39:0] mulModel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return {32'h40000000, 8'h00};
      {32'h40000000, 32'h40400000}: return {32'h40C00000, 8'h00};
      {32'h00000000, 32'h7F800000}: return {32'h7FC00000, 8'h20};
      default:                      return {32'hDEADBEEF, 8'hFF};
    endcase
  endfunction

  logic [39:0] mulPipe [LAT];
  always @(posedge clk) begin
    mulPipe[0] <= mulModel(mult_a, mult_b);
    for (int k = 1; k < LAT; k++) mulPipe[k] <= mulPipe[k-1];
  end
  assign mult_z      = mulPipe[LAT-1][39:8];
  assign mult_status = mulPipe[LAT-1][7:0];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] ready);
    req_valid  = valid;
    resp_ready = ready;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic setDefaultOperands();
    req_a   = {32'h40000000, 32'h3F800000};
    req_b   = {32'h40400000, 32'h40000000};
    req_rnd = {3'd1, 3'd0};
  endtask

  initial begin
    logic [1:0] expReady;
    logic [1:0] expResp;

    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
`ifdef STATUS_STICKY_EN
    sticky_clr = '0;
`endif
    setDefaultOperands();
    nextCycle();
    nextCycle();

    // Reset state
    applyStimulus(2'b00, 2'b00);
    checkOutput("rst resp_valid", resp_valid, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst mult_valid", mult_valid, 0);
    checkOutput("rst mult_a", mult_a, 0);
    checkOutput("rst resp_z", resp_z, 0);
    rst = 1'b0;
    nextCycle();

    // Single request from requester 0
    applyStimulus(2'b01, 2'b00);
    checkOutput("single grant", req_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("single mult_valid", mult_valid, 1);
    checkOutput("single mult_a", mult_a, 32'h3F800000);
    checkOutput("single mult_b", mult_b, 32'h40000000);
    checkOutput("single mult_rnd", mult_rnd, 0);
    checkOutput("single busy", busy, 1);
    for (int t = 2; t <= LAT + 1; t++) begin
      nextCycle();
      checkOutput("single early resp", {mult_valid, resp_valid}, 3'b000);
    end
    nextCycle();
    checkOutput("single resp_valid", resp_valid, 2'b01);
    checkOutput("single resp_z", resp_z[31:0], 32'h40000000);
    checkOutput("single status", resp_status[7:0], 8'h00);
    for (int h = 0; h < 3; h++) begin
      nextCycle();
      checkOutput("single hold", {resp_valid, resp_z[31:0]}, {2'b01, 32'h40000000});
    end
    applyStimulus(2'b00, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("single done", {resp_valid, busy}, 3'b000);

    // Both requesting continuously with both consumers ready
    doReset();
    for (int t = 0; t < 3 * P; t++) begin
      applyStimulus(2'b11, 2'b11);
      expReady = (t % P == 0) ? 2'b01 : (t % P == 1) ? 2'b10 : 2'b00;
      expResp  = (t % P == P - 1) ? 2'b01 : (t % P == 0 && t > 0) ? 2'b10 : 2'b00;
      checkOutput($sformatf("rr grant t%0d", t), req_ready, expReady);
      checkOutput($sformatf("rr resp t%0d", t), resp_valid, expResp);
      if (t >= 1) checkOutput($sformatf("rr busy t%0d", t), busy, 1);
      if (expResp[0]) checkOutput("rr z0", resp_z[31:0], 32'h40000000);
      if (expResp[1]) checkOutput("rr z1", resp_z[63:32], 32'h40C00000);
      if (t == 2) checkOutput("rr mult_rnd", {mult_rnd, mult_a}, {3'd1, 32'h40000000});
      nextCycle();
    end
    applyStimulus(2'b00, 2'b11);
    checkOutput("rr last resp", resp_valid, 2'b10);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("rr drained", {resp_valid, busy}, 3'b000);

    // Requester 1 holds its response; requester 0 keeps going
    doReset();
    for (int t = 0; t < 3 * P; t++) begin
      applyStimulus(2'b11, 2'b01);
      expReady   = (t == 1) ? 2'b10 : (t % P == 0) ? 2'b01 : 2'b00;
      expResp[0] = (t % P == P - 1);
      expResp[1] = (t >= LAT + 3);
      checkOutput($sformatf("blk grant t%0d", t), req_ready, expReady);
      checkOutput($sformatf("blk resp t%0d", t), resp_valid, expResp);
      if (expResp[1]) checkOutput($sformatf("blk z1 t%0d", t), resp_z[63:32], 32'h40C00000);
      nextCycle();
    end
    applyStimulus(2'b00, 2'b11);
    checkOutput("blk release", resp_valid, 2'b10);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("blk drained", {resp_valid, busy}, 3'b000);

    // 0 * inf gives nan
    doReset();
    req_a[31:0] = 32'h00000000;
    req_b[31:0] = 32'h7F800000;
    applyStimulus(2'b01, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    repeat (LAT + 1) nextCycle();
    checkOutput("nan resp_valid", resp_valid, 2'b01);
    checkOutput("nan z", resp_z[31:0], 32'h7FC00000);
    checkOutput("nan status", resp_status[7:0], 8'h20);
`ifdef STATUS_STICKY_EN
    checkOutput("sticky set", sticky_status[7:0], 8'h20);
`endif
    applyStimulus(2'b00, 2'b01);
    nextCycle();
    setDefaultOperands();
    applyStimulus(2'b01, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    repeat (LAT + 1) nextCycle();
    checkOutput("clean status", {resp_valid, resp_status[7:0]}, {2'b01, 8'h00});
`ifdef STATUS_STICKY_EN
    checkOutput("sticky kept", sticky_status[7:0], 8'h20);
    sticky_clr = 2'b01;
`endif
    applyStimulus(2'b00, 2'b01);
    nextCycle();
`ifdef STATUS_STICKY_EN
    sticky_clr = 2'b00;
    checkOutput("sticky cleared", sticky_status[7:0], 8'h00);
`endif
    applyStimulus(2'b00, 2'b00);
    checkOutput("clean done", {resp_valid, busy}, 3'b000);

    // Reset two cycles after an accept discards the in-flight result
    doReset();
    applyStimulus(2'b01, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b10, 2'b00);
    checkOutput("midrst ready", req_ready, 2'b00);
    nextCycle();
    rst = 1'b0;
    applyStimulus(2'b00, 2'b11);
    checkOutput("midrst outputs", {mult_valid, mult_a, busy, resp_valid}, 36'h0);
    for (int t = 0; t < 6; t++) begin
      nextCycle();
      checkOutput($sformatf("midrst no resp t%0d", t), resp_valid, 2'b00);
    end
    applyStimulus(2'b01, 2'b00);
    checkOutput("post rst grant", req_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00);
    repeat (LAT + 1) nextCycle();
    checkOutput("post rst resp", {resp_valid, resp_z[31:0]}, {2'b01, 32'h40000000});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
